// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP histogram block.
package lbp_pkg;

  localparam int IMG_W  = 128;
  localparam int CNT_W  = 15;
  localparam int NBINS  = 256;
  localparam int ROW_W  = $clog2(IMG_W);
  localparam int ADDR_W = 2 * ROW_W;

  typedef logic [7:0]       lbp_code_t;
  typedef logic [CNT_W-1:0] hist_cnt_t;

  typedef enum logic [1:0] {
    CLEAR,
    ACCUM,
    DRAIN,
    READOUT
  } hist_state_t;

endpackage

// File: rtl/lbp_hist_ram.sv
// 256-entry bin storage: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module lbp_hist_ram
  import lbp_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [7:0]       waddr,
  input  logic [CNT_W-1:0] wdata,
  input  logic [7:0]       raddr,
  output logic [CNT_W-1:0] rdata
);

  hist_cnt_t mem [NBINS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lbp_hist.sv
// 256-bin histogram of LBP codes for one frame, drained over a valid/ready port.
// Optional build macro LBP_HIST_SKIP_BORDER_EN: ignore beats on the frame border.
module lbp_hist
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [7:0]        lbp_data,
  input  logic              finish,
  output logic              hist_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_bin,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  output logic              err_drop
);

  hist_state_t state, state_nxt;

  lbp_code_t clr_idx;
  logic      drain_cnt;
  logic      on_border;
  logic      beat_ok;
  logic      accept_out;

  logic      s1_valid;
  lbp_code_t s1_bin;
  logic      fwd_valid;
  lbp_code_t fwd_bin;
  hist_cnt_t fwd_val;
  hist_cnt_t s2_base, s2_val;

  logic      ram_we;
  lbp_code_t ram_waddr, ram_raddr;
  hist_cnt_t ram_wdata, ram_rdata;

`ifdef LBP_HIST_SKIP_BORDER_EN
  logic [ROW_W-1:0] row, col;
  assign row = lbp_addr[ADDR_W-1:ROW_W];
  assign col = lbp_addr[ROW_W-1:0];
  assign on_border = (row == '0) || (row == ROW_W'(IMG_W - 1)) ||
                     (col == '0) || (col == ROW_W'(IMG_W - 1));
`else
  logic unused_addr;
  assign unused_addr = ^lbp_addr;
  assign on_border   = 1'b0;
`endif

  assign beat_ok    = lbp_valid && (state == ACCUM) && !on_border;
  assign accept_out = (state == READOUT) && out_ready;

  // The storage read for S2 lags the previous write by one cycle, so a
  // same-bin beat directly behind takes the value just written instead.
  assign s2_base = (fwd_valid && (fwd_bin == s1_bin)) ? fwd_val : ram_rdata;
  assign s2_val  = (s2_base == '1) ? s2_base : s2_base + hist_cnt_t'(1);

  always_comb begin
    ram_we    = s1_valid;
    ram_waddr = s1_bin;
    ram_wdata = s2_val;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_idx;
      ram_wdata = '0;
    end
  end

  lbp_hist_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hist_busy = 1'b1;
    out_valid = 1'b0;
    ram_raddr = '0;
    case (state)
      CLEAR: begin
        if (clr_idx == 8'(NBINS - 1)) state_nxt = ACCUM;
      end
      ACCUM: begin
        hist_busy = 1'b0;
        ram_raddr = lbp_data;
        if (finish) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Bin 0 is fetched during the last drain cycle so it is ready on entry.
        if (drain_cnt) state_nxt = READOUT;
      end
      READOUT: begin
        out_valid = 1'b1;
        ram_raddr = accept_out ? out_bin + 8'd1 : out_bin;
        if (accept_out && (out_bin == 8'(NBINS - 1))) state_nxt = CLEAR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign out_last  = out_valid && (out_bin == 8'(NBINS - 1));
  assign out_count = out_valid ? ram_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_idx   <= '0;
      drain_cnt <= 1'b0;
      out_bin   <= '0;
      s1_valid  <= 1'b0;
      s1_bin    <= '0;
      fwd_valid <= 1'b0;
      fwd_bin   <= '0;
      fwd_val   <= '0;
      err_drop  <= 1'b0;
    end else begin
      clr_idx   <= (state == CLEAR) ? clr_idx + 8'd1 : '0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (accept_out) out_bin <= out_bin + 8'd1;
      s1_valid  <= beat_ok;
      s1_bin    <= lbp_data;
      fwd_valid <= s1_valid;
      fwd_bin   <= s1_bin;
      fwd_val   <= s2_val;
      if (lbp_valid && (state != ACCUM)) err_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lbp_hist.sv
// Self-checking bench for lbp_hist against a per-bin count model.
module tb_lbp_hist;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr = '0;
  logic [7:0]  lbp_data = '0;
  logic        finish = 1'b0;
  logic        out_ready = 1'b0;
  logic        hist_busy, out_valid, out_last, err_drop;
  logic [7:0]  out_bin;
  logic [14:0] out_count;

  int errors = 0;
  int checks = 0;
  int model [256];

  always #5 clk = ~clk;

  lbp_hist dut (
    .clk       (clk),
    .reset     (reset),
    .lbp_valid (lbp_valid),
    .lbp_addr  (lbp_addr),
    .lbp_data  (lbp_data),
    .finish    (finish),
    .hist_busy (hist_busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_count (out_count),
    .out_last  (out_last),
    .err_drop  (err_drop)
  );

  function automatic bit skip_beat(input int addr);
`ifdef LBP_HIST_SKIP_BORDER_EN
    int r, c;
    r = addr / 128;
    c = addr % 128;
    return (r == 0) || (r == 127) || (c == 0) || (c == 127);
`else
    return (addr < 0);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 0;
  endtask

  task automatic beat(input logic [7:0] code, input logic [13:0] addr, input bit with_finish);
    lbp_valid = 1'b1;
    lbp_data  = code;
    lbp_addr  = addr;
    finish    = with_finish;
    step();
    lbp_valid = 1'b0;
    finish    = 1'b0;
    if (!skip_beat(int'(addr)) && model[code] < 32767) model[code]++;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    while (hist_busy && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (hist_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s clear_timeout: hist_busy=%0b after %0d cycles, required 0", name, hist_busy, n);
    end
  endtask

  // Entered one cycle after the finish edge; walks all 256 bins against the model.
  task automatic readout(input bit rand_ready, input bit inject, input string name);
    int idx = 0;
    int guard = 0;
    bit v, r;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s valid_f1: out_valid=%0b required 0", name, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s valid_f2: out_valid=%0b required 0", name, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s valid_f3: out_valid=%0b required 1", name, out_valid);
    end
    while (idx < 256 && guard < 3000) begin
      guard++;
      v = out_valid;
      checks++;
      if (v !== 1'b1) begin
        errors++; $display("FAIL %s valid bin %0d: out_valid=%0b required 1", name, idx, v);
      end else begin
        checks++;
        if (out_bin !== 8'(idx)) begin
          errors++; $display("FAIL %s out_bin: got %0d required %0d", name, out_bin, idx);
        end
        checks++;
        if (out_count !== 15'(model[idx])) begin
          errors++; $display("FAIL %s out_count bin %0d: got %0d required %0d", name, idx, out_count, model[idx]);
        end
        checks++;
        if (out_last !== 1'(idx == 255)) begin
          errors++; $display("FAIL %s out_last bin %0d: got %0b required %0b", name, idx, out_last, idx == 255);
        end
      end
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (inject) begin
        lbp_valid = 1'($urandom_range(0, 1));
        lbp_data  = 8'd9;
        lbp_addr  = 14'd300;
        finish    = 1'($urandom_range(0, 1));
      end
      step();
      if (v && r) idx++;
    end
    out_ready = 1'b0;
    lbp_valid = 1'b0;
    finish    = 1'b0;
    checks++;
    if (idx != 256) begin
      errors++; $display("FAIL %s readout_timeout: got %0d bins required 256", name, idx);
    end
    checks++;
    if ({hist_busy, out_valid} !== 2'b10) begin
      errors++; $display("FAIL %s post_readout busy/valid: got %b required 10", name, {hist_busy, out_valid});
    end
    clear_model();
  endtask

  task automatic test_reset();
    int n = 0;
    reset = 1'b1;
    clear_model();
    step();
    checks++;
    if ({hist_busy, out_valid, out_bin, out_count, out_last, err_drop} !== {1'b1, 1'b0, 8'd0, 15'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_values: got %b required %b",
        {hist_busy, out_valid, out_bin, out_count, out_last, err_drop}, {1'b1, 1'b0, 8'd0, 15'd0, 1'b0, 1'b0});
    end
    reset = 1'b0;
    while (hist_busy && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL clear_length: hist_busy fell after %0d cycles, required 256", n);
    end
    repeat (300 - n) step();
    checks++;
    if (hist_busy !== 1'b0) begin
      errors++; $display("FAIL idle_accum: hist_busy=%0b required 0", hist_busy);
    end
    pulse_finish();
    readout(1'b0, 1'b0, "empty_frame");
  endtask

  task automatic test_back_to_back();
    wait_clear("b2b");
    repeat (3) beat(8'd3, 14'd200, 1'b0);
    repeat (3) beat(8'd255, 14'd201, 1'b0);
    beat(8'd7, 14'd202, 1'b0);
    beat(8'd8, 14'd203, 1'b0);
    beat(8'd7, 14'd204, 1'b0);
    beat(8'd8, 14'd205, 1'b0);
    beat(8'd7, 14'd206, 1'b1);
    readout(1'b0, 1'b0, "b2b");
  endtask

  task automatic test_full_frame();
    wait_clear("frame");
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++) begin
        bit border = (r == 0) || (r == 127) || (c == 0) || (c == 127);
        beat(border ? 8'h00 : 8'hAA, 14'(r * 128 + c), 1'b0);
      end
    pulse_finish();
    readout(1'b0, 1'b0, "frame");
  endtask

  task automatic test_random_stall();
    logic [7:0] code;
    wait_clear("stall");
    for (int i = 0; i < 400; i++) begin
      code = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
      beat(code, 14'($urandom_range(0, 16383)), 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
    end
    beat(8'd5, 14'd500, 1'b1);
    readout(1'b1, 1'b0, "stall");
  endtask

  task automatic test_drop();
    wait_clear("drop");
    checks++;
    if (err_drop !== 1'b0) begin
      errors++; $display("FAIL drop_before: err_drop=%0b required 0", err_drop);
    end
    beat(8'd9, 14'd129, 1'b0);
    beat(8'd10, 14'd130, 1'b0);
    pulse_finish();
    readout(1'b1, 1'b1, "drop_readout");
    lbp_valid = 1'b1; lbp_data = 8'd9; lbp_addr = 14'd131;
    step();
    lbp_valid = 1'b0;
    checks++;
    if (err_drop !== 1'b1) begin
      errors++; $display("FAIL drop_sticky: err_drop=%0b required 1", err_drop);
    end
    wait_clear("drop_next");
    pulse_finish();
    readout(1'b0, 1'b0, "drop_next");
  endtask

  task automatic test_reset_mid_accum();
    int n = 0;
    wait_clear("midreset");
    for (int i = 0; i < 100; i++) beat(8'h55, 14'(129 + i), 1'b0);
    lbp_valid = 1'b1; lbp_data = 8'h55; lbp_addr = 14'd240;
    #2 reset = 1'b1;
    lbp_valid = 1'b0;
    clear_model();
    #1;
    checks++;
    if ({hist_busy, out_valid, out_bin, out_count, out_last, err_drop} !== {1'b1, 1'b0, 8'd0, 15'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midreset_values: got %b required %b",
        {hist_busy, out_valid, out_bin, out_count, out_last, err_drop}, {1'b1, 1'b0, 8'd0, 15'd0, 1'b0, 1'b0});
    end
    step();
    reset = 1'b0;
    while (hist_busy && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL midreset_clear_length: got %0d cycles required 256", n);
    end
    for (int i = 0; i < 10; i++) beat(8'h55, 14'(300 + i), 1'b0);
    pulse_finish();
    readout(1'b1, 1'b0, "midreset_next");
  endtask

  task automatic test_saturation();
    wait_clear("sat");
    for (int i = 0; i < 32770; i++) beat(8'd7, 14'd129, 1'b0);
    repeat (2) beat(8'd255, 14'd130, 1'b0);
    pulse_finish();
    readout(1'b0, 1'b0, "sat");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_frame();
    test_random_stall();
    test_drop();
    test_reset_mid_accum();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
